pcie_wrr_scheduler: RTL and testbench
=====================================

# pcie_wrr_scheduler

Weighted round-robin scheduler for the transaction-layer crossbar. It decides each cycle which of the four input (naranja) FIFOs is popped. It steers the popped word to the output (morado) FIFO named by the word's destination field, and it holds off any output FIFO that reports almost-full. It replaces the fixed-priority pop/push logic between the input FIFOs and the output FIFOs. It is gated by the main FSM state.

## Interface
Parameters:
- DATA_W, 10, word width.
- DEST_LSB, 8, destination class = data[DEST_LSB+1:DEST_LSB].
- CNT_W, 8, width of the transferred-word counter.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- state  in  4  FSM state, one-hot (package constants).
- empty_in  in  4  input FIFO empty flags, bit i = FIFO_in i.
- head0..head3  in  DATA_W  head word of input FIFO i; first-word-fall-through, valid while !empty_in[i].
- almost_full_out  in  4  output FIFO almost-full flags.
- weight0..weight3  in  2  per-class weight; sampled only in ST_INIT.
- pop  out  4  one-hot pop to input FIFOs; combinational.
- push_out  out  4  one-hot push to output FIFOs; registered.
- data_out  out  DATA_W  word accompanying push_out; registered.
- idle  out  1  high in ST_ACTIVE when all inputs are empty and push_out==0.
- words_moved  out  CNT_W  count of completed pushes; wraps.

## Operation
- Registers:
  - wt[3:0][1:0]: latched weights.
  - ptr[1:0]: current class.
  - cred[2:0]: grants remaining for ptr, range 1..4.
  - push_out, data_out, words_moved.
- Weight latch: while state==ST_INIT, wt[i] <= weight_i each cycle.
- Eligibility: elig[i] = !empty_in[i] & !almost_full_out[head_i dest].
- Grants only in ST_ACTIVE. In all other states pop=0 and ptr/cred hold.
- Grant selection:
  - If elig[ptr], then g=ptr and used=cred.
  - Otherwise g = first eligible in the order ptr+1, ptr+2, ptr+3 (mod 4), and used = wt[g]+1.
  - If nothing is eligible, there is no grant and registers hold.
- On a grant:
  - pop[g]=1.
  - If used-1==0: ptr <= g+1 and cred <= wt[g+1]+1.
  - Otherwise: ptr <= g and cred <= used-1.
- Result: class i receives wt[i]+1 consecutive grants per turn while it stays eligible. An ineligible class forfeits its remaining credit.
- Steering: on the cycle after the grant, push_out[dest(head_g)]=1 and data_out=head_g as sampled at the grant edge. In all other cycles push_out=0 and data_out holds its value.
- words_moved increments on every cycle with push_out!=0 and wraps from 2^CNT_W-1 to 0.
- Leaving ST_ACTIVE: pop drops in the same cycle. A push already in flight still completes and is counted; no popped word is ever dropped.
- Reset clears the following:
  - wt=0, ptr=0, cred=1.
  - push_out=0, data_out=0, words_moved=0.
  - idle=0.
- Reset mid-operation: the in-flight push is discarded, because the whole datapath is reset together.

## Timing
- Throughput is one grant per cycle.
- pop is Mealy: combinational from ptr/cred and the current empty_in, almost_full_out and head.
- Pop-to-push latency is 1 cycle.
- Almost-full margin: a grant at N pushes at N+1, so almost_full_out must assert with ≥2 free entries left. The output FIFO umbral_superior is configured accordingly.
- A FIFO holding one word gets pop at N and is seen empty at N+1; no special casing is needed.
- Weight changes outside ST_INIT are ignored.
- cred reload uses the wt value current at the grant edge.

## Structure
- Shared package pcie_tl_pkg:
  - state constants ST_RESET=4'b0001, ST_INIT=4'b0010, ST_IDLE=4'b0100, ST_ACTIVE=4'b1000.
  - DATA_W, DEST_LSB, the class count (4).
- Sub-module rr_pick4: combinational circular first-one finder (4-bit request, 2-bit start index) returning found and index.
- All state is in the top module.

## Test plan
- Reset: assert reset for 2 cycles with a random state → pop=0, push_out=0, data_out=0, words_moved=0, idle=0.
- Equal weights:
  - Stimulus: weights all 0 (INIT), ACTIVE, all four inputs full, head_i dest=i, no almost-full.
  - Expected: pop sequence 0,1,2,3,0,…, one per cycle; push_out[i] one cycle after pop[i] with matching data.
- Weighted:
  - Stimulus: weights 3,0,1,0, all inputs non-empty.
  - Expected: pop order 0,0,0,0,1,2,2,3,0,…
- Backpressure:
  - Stimulus: head1 dest=2, almost_full_out[2]=1.
  - Expected: input 1 is never popped while the others rotate. Drop almost_full_out[2] → input 1 is granted at its next turn.
- State exit:
  - Stimulus: leave ACTIVE on the cycle pop[2]=1.
  - Expected: pop=0 from the next cycle; push_out[dest] still fires once; words_moved +1; idle=0.
- Wrap and reset:
  - Stimulus: 256 transfers, then reset mid-stream.
  - Expected: words_moved goes 255→0; after reset, ptr=0 so the first grant goes to input 0.

Source files
------------

// File: rtl/pcie_tl_pkg.sv
// Shared transaction-layer definitions: main FSM state encoding, word layout
// and a one-hot helper used by the crossbar scheduling logic.
package pcie_tl_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } tl_state_e;

    localparam int DATA_W      = 10;
    localparam int DEST_LSB    = 8;
    localparam int NUM_CLASSES = 4;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/pcie_wrr_scheduler_if.sv
// Handshake bundle between the input FIFOs, the scheduler and the output FIFOs.
// The scheduler takes the master side; FIFO models take the slave side.
interface pcie_wrr_scheduler_if #(
    parameter int DATA_W = pcie_tl_pkg::DATA_W
);
    import pcie_tl_pkg::*;

    logic [3:0]        empty_in;
    logic [DATA_W-1:0] head0;
    logic [DATA_W-1:0] head1;
    logic [DATA_W-1:0] head2;
    logic [DATA_W-1:0] head3;
    logic [3:0]        almost_full_out;
    logic [3:0]        pop;
    logic [3:0]        push_out;
    logic [DATA_W-1:0] data_out;

    modport master (
        input  empty_in, head0, head1, head2, head3, almost_full_out,
        output pop, push_out, data_out
    );

    modport slave (
        output empty_in, head0, head1, head2, head3, almost_full_out,
        input  pop, push_out, data_out
    );

endinterface

// File: rtl/pcie_wrr_scheduler_rr_pick4.sv
// Circular first-one finder over four requests, searching upward from start_i
// and wrapping; reports whether anything was found and at which index.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] start_i,
    output logic       found_o,
    output logic [1:0] idx_o
);

    logic [1:0] cand;

    // Walk offsets from the far end down so the nearest request wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        cand    = start_i;
        for (int k = 3; k >= 0; k--) begin
            cand = start_i + 2'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/pcie_wrr_scheduler.sv
// Weighted round-robin pop/push scheduler between the four input FIFOs and the
// four output FIFOs of the transaction-layer crossbar.
module pcie_wrr_scheduler #(
    parameter int DATA_W   = pcie_tl_pkg::DATA_W,
    parameter int DEST_LSB = pcie_tl_pkg::DEST_LSB,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state,
    pcie_wrr_scheduler_if.master bus,
    input  logic [1:0]           weight0,
    input  logic [1:0]           weight1,
    input  logic [1:0]           weight2,
    input  logic [1:0]           weight3,
    output logic                 idle,
    output logic [CNT_W-1:0]     words_moved
);
    import pcie_tl_pkg::*;

    logic [3:0][1:0]        wt_q, wt_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [2:0]             cred_q, cred_d;
    logic [3:0]             push_q, push_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [3:0][DATA_W-1:0] head;
    logic [3:0][1:0]        dest;
    logic [3:0]             elig;
    logic                   pick_found;
    logic [1:0]             pick_idx;
    logic                   active;
    logic                   grant;
    logic [1:0]             gnt_idx;
    logic [1:0]             next_ptr;
    logic [2:0]             used;

    assign head[0] = bus.head0;
    assign head[1] = bus.head1;
    assign head[2] = bus.head2;
    assign head[3] = bus.head3;

    // A class is eligible only when it has a word and that word's target can take it.
    always_comb begin
        dest = '0;
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            dest[i] = head[i][DEST_LSB+1:DEST_LSB];
            elig[i] = !bus.empty_in[i] && !bus.almost_full_out[dest[i]];
        end
    end

    rr_pick4 u_pick (
        .req_i   (elig),
        .start_i (ptr_q + 2'd1),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        active   = (state == ST_ACTIVE) && !reset;
        gnt_idx  = elig[ptr_q] ? ptr_q : pick_idx;
        used     = elig[ptr_q] ? cred_q : ({1'b0, wt_q[pick_idx]} + 3'd1);
        grant    = active && (elig[ptr_q] || pick_found);
        next_ptr = gnt_idx + 2'd1;

        wt_d   = (state == ST_INIT) ? {weight3, weight2, weight1, weight0} : wt_q;
        ptr_d  = ptr_q;
        cred_d = cred_q;
        push_d = 4'b0000;
        data_d = data_q;
        cnt_d  = cnt_q + ((push_q != 4'b0000) ? CNT_W'(1) : CNT_W'(0));

        // Staying on a class while it has credit; otherwise hand the turn on with a fresh reload.
        if (grant) begin
            if (used == 3'd1) begin
                ptr_d  = next_ptr;
                cred_d = {1'b0, wt_q[next_ptr]} + 3'd1;
            end else begin
                ptr_d  = gnt_idx;
                cred_d = used - 3'd1;
            end
            push_d = onehot4(dest[gnt_idx]);
            data_d = head[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wt_q   <= '0;
            ptr_q  <= 2'd0;
            cred_q <= 3'd1;
            push_q <= 4'b0000;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            wt_q   <= wt_d;
            ptr_q  <= ptr_d;
            cred_q <= cred_d;
            push_q <= push_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.pop      = grant ? onehot4(gnt_idx) : 4'b0000;
    assign bus.push_out = push_q;
    assign bus.data_out = data_q;
    assign words_moved  = cnt_q;
    assign idle         = (state == ST_ACTIVE) && !reset && (&bus.empty_in) && (push_q == 4'b0000);

endmodule

// File: tb/tb_pcie_wrr_scheduler.sv
// Directed bench for the weighted round-robin scheduler: hand-derived pop
// orders with a small push/count model carried from cycle to cycle.
module tb_pcie_wrr_scheduler;
    import pcie_tl_pkg::*;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    state;
    logic [1:0]    weight [4];
    logic          idle;
    logic [CW-1:0] wordsMoved;
    logic [DW-1:0] headWord [4];

    int            checks   = 0;
    int            failures = 0;
    logic [3:0]    expPush;
    logic [DW-1:0] expData;
    logic [CW-1:0] expCount;

    always #5 clk = ~clk;

    pcie_wrr_scheduler_if #(.DATA_W(DW)) busIf ();

    assign busIf.head0 = headWord[0];
    assign busIf.head1 = headWord[1];
    assign busIf.head2 = headWord[2];
    assign busIf.head3 = headWord[3];

    pcie_wrr_scheduler #(.DATA_W(DW), .DEST_LSB(8), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .bus         (busIf),
        .weight0     (weight[0]),
        .weight1     (weight[1]),
        .weight2     (weight[2]),
        .weight3     (weight[3]),
        .idle        (idle),
        .words_moved (wordsMoved)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2, input logic [1:0] d3);
        headWord[0] = {d0, 8'hA0};
        headWord[1] = {d1, 8'hB1};
        headWord[2] = {d2, 8'hC2};
        headWord[3] = {d3, 8'hD3};
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic runCycle(input int expG, input string tag);
        logic [3:0] expPop;
        logic       expIdle;
        #3;
        expPop  = (expG < 0) ? 4'b0000 : 4'(1 << expG);
        expIdle = (state == ST_ACTIVE) && (busIf.empty_in == 4'hF) && (expPush == 4'b0000);
        checkOutput({tag, ":pop"},   32'(busIf.pop),      32'(expPop));
        checkOutput({tag, ":push"},  32'(busIf.push_out), 32'(expPush));
        checkOutput({tag, ":data"},  32'(busIf.data_out), 32'(expData));
        checkOutput({tag, ":words"}, 32'(wordsMoved),     32'(expCount));
        checkOutput({tag, ":idle"},  32'(idle),           32'(expIdle));
        if (expPush != 4'b0000) expCount = expCount + 1'b1;
        if (expG >= 0) begin
            expPush = 4'(1 << headWord[expG][9:8]);
            expData = headWord[expG];
        end else begin
            expPush = 4'b0000;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        reset                 = 1'b1;
        state                 = ST_ACTIVE;
        busIf.empty_in        = 4'h0;
        busIf.almost_full_out = 4'h0;
        #3;
        checkOutput("rst1:pop",  32'(busIf.pop), 32'h0);
        checkOutput("rst1:idle", 32'(idle),      32'h0);
        @(posedge clk);
        #1;
        state          = 4'(1 << $urandom_range(0, 3));
        busIf.empty_in = 4'hF;
        #3;
        checkOutput("rst2:pop",   32'(busIf.pop),      32'h0);
        checkOutput("rst2:push",  32'(busIf.push_out), 32'h0);
        checkOutput("rst2:data",  32'(busIf.data_out), 32'h0);
        checkOutput("rst2:words", 32'(wordsMoved),     32'h0);
        checkOutput("rst2:idle",  32'(idle),           32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        expPush  = 4'b0000;
        expData  = '0;
        expCount = '0;
    endtask

    task automatic initWeights(input logic [1:0] w0, input logic [1:0] w1, input logic [1:0] w2, input logic [1:0] w3);
        state     = ST_INIT;
        weight[0] = w0;
        weight[1] = w1;
        weight[2] = w2;
        weight[3] = w3;
        runCycle(-1, "init");
    endtask

    task automatic scrambleWeights();
        for (int i = 0; i < 4; i++) weight[i] = 2'($urandom_range(0, 3));
    endtask

    int eqSeq  [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int wtSeq  [13] = '{0, 1, 2, 2, 3, 0, 0, 0, 0, 1, 2, 2, 3};
    int bpSeq  [6]  = '{0, 2, 3, 0, 2, 3};
    int relSeq [4]  = '{0, 1, 2, 3};

    initial begin
        reset = 1'b1;
        state = ST_RESET;
        for (int i = 0; i < 4; i++) weight[i] = 2'd0;
        busIf.empty_in        = 4'hF;
        busIf.almost_full_out = 4'h0;
        applyStimulus(2'd0, 2'd1, 2'd2, 2'd3);
        expPush  = 4'b0000;
        expData  = '0;
        expCount = '0;
        @(posedge clk);
        #1;

        // Equal weights: plain rotation, weight inputs ignored once active.
        resetDut();
        busIf.empty_in = 4'h0;
        initWeights(2'd0, 2'd0, 2'd0, 2'd0);
        state = ST_ACTIVE;
        scrambleWeights();
        foreach (eqSeq[k]) runCycle(eqSeq[k], "equal");

        // Weights 3,0,1,0 latched while the old credit of 1 on class 0 is still pending.
        initWeights(2'd3, 2'd0, 2'd1, 2'd0);
        state = ST_ACTIVE;
        scrambleWeights();
        foreach (wtSeq[k]) runCycle(wtSeq[k], "weighted");

        // Backpressure: input 1 targets output 2, which is almost full.
        resetDut();
        busIf.empty_in = 4'h0;
        initWeights(2'd0, 2'd0, 2'd0, 2'd0);
        applyStimulus(2'd0, 2'd2, 2'd0, 2'd3);
        busIf.almost_full_out = 4'b0100;
        state = ST_ACTIVE;
        foreach (bpSeq[k]) runCycle(bpSeq[k], "bp_hold");
        busIf.almost_full_out = 4'b0000;
        foreach (relSeq[k]) runCycle(relSeq[k], "bp_release");

        // Leave ACTIVE right after the grant to input 2; its push must still land.
        applyStimulus(2'd0, 2'd1, 2'd2, 2'd3);
        runCycle(0, "exit_pre");
        runCycle(1, "exit_pre");
        runCycle(2, "exit_grant");
        state = ST_IDLE;
        runCycle(-1, "exit_flush");
        runCycle(-1, "exit_after");

        // All inputs empty while active with nothing in flight.
        state          = ST_ACTIVE;
        busIf.empty_in = 4'hF;
        runCycle(-1, "idle_on");

        // Counter wrap over 256+ transfers, then reset mid-stream.
        resetDut();
        busIf.empty_in = 4'h0;
        state          = ST_ACTIVE;
        for (int k = 0; k < 260; k++) runCycle(k % 4, "wrap");
        resetDut();
        busIf.empty_in = 4'h0;
        state          = ST_ACTIVE;
        runCycle(0, "post_reset");
        runCycle(1, "post_reset");
        runCycle(2, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
